// File: rtl/sprite_cfg_if.sv
// Pin-side and datapath-side signals of the sprite configuration sequencer.
// sprite_we is a one-cycle write strobe with no back-pressure; sprite_addr/sprite_wdata are meaningful only while it is high.
interface sprite_cfg_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           spi_clk;
  logic           spi_data;
  logic           next_frame;
  logic [X_W-1:0] sprite_x;
  logic [Y_W-1:0] sprite_y;
  logic [5:0]     color_bg;
  logic [5:0]     color_fg;
  logic           sprite_we;
  logic [7:0]     sprite_addr;
  logic [7:0]     sprite_wdata;
  logic           cfg_update;
  logic           busy;
  logic           state_dbg;

  modport master (
    input  spi_clk, spi_data, next_frame,
    output sprite_x, sprite_y, color_bg, color_fg, sprite_we, sprite_addr,
           sprite_wdata, cfg_update, busy, state_dbg
  );

  modport slave (
    output spi_clk, spi_data, next_frame,
    input  sprite_x, sprite_y, color_bg, color_fg, sprite_we, sprite_addr,
           sprite_wdata, cfg_update, busy, state_dbg
  );
endinterface

// File: rtl/sprite_cfg_sequencer.sv
// SPI-to-sprite configuration sequencer: deserialises SPI bytes, decodes fixed-length commands,
// writes sprite RAM directly and commits shadowed position/colour atomically on next_frame.
module sprite_cfg_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic         clk,
  input  logic         reset,
  sprite_cfg_if.master bus
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic {CMD = 1'b0, PAYLOAD = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, clk_s, data_s, rise;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_reg;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic [IDLE_W-1:0]      idle_cnt;
  logic                   busy, timeout_hit;

  state_t      state, state_d;
  logic [1:0]  rem_cnt, rem_d;
  logic [7:0]  op, op_d;
  logic [3:0]  pay0, pay0_d;
  logic [7:0]  pay1, pay1_d;
  logic        exec_pos, exec_col, exec_wr;
  logic [19:0] pos_word;
  logic        commit;

  logic [X_W-1:0] shadow_x, act_x;
  logic [Y_W-1:0] shadow_y, act_y;
  logic [5:0]     shadow_bg, shadow_fg, act_bg, act_fg;
  logic           dirty, we_q, cfg_q;
  logic [7:0]     addr_q, wdata_q;

  function automatic logic [1:0] cmd_len(input logic [7:0] opcode);
    case (opcode)
      8'h01:        cmd_len = 2'd3;
      8'h02, 8'h03: cmd_len = 2'd2;
      default:      cmd_len = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.spi_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s       = clk_sync[SYNC_STAGES-1];
  assign data_s      = data_sync[SYNC_STAGES-1];
  assign rise        = clk_s & ~clk_prev;
  assign byte_in     = {shift_reg, data_s};
  assign byte_valid  = rise && (bit_cnt == 3'd7);
  assign busy        = (bit_cnt != 3'd0) || (state == PAYLOAD);
  assign timeout_hit = busy && !rise && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  // Bit counter wraps naturally after the eighth edge; a timeout drops any partial byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      idle_cnt  <= '0;
    end else begin
      if (rise) begin
        shift_reg <= byte_in[6:0];
        bit_cnt   <= bit_cnt + 3'd1;
        idle_cnt  <= '0;
      end else if (timeout_hit) begin
        bit_cnt  <= 3'd0;
        idle_cnt <= '0;
      end else if (busy) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CMD;
      rem_cnt <= 2'd0;
      op      <= 8'h00;
      pay0    <= 4'h0;
      pay1    <= 8'h00;
    end else begin
      state   <= state_d;
      rem_cnt <= rem_d;
      op      <= op_d;
      pay0    <= pay0_d;
      pay1    <= pay1_d;
    end
  end

  // Payload bytes shift through pay1 -> pay0, so the final byte is consumed straight from byte_in.
  always_comb begin
    state_d  = state;
    rem_d    = rem_cnt;
    op_d     = op;
    pay0_d   = pay0;
    pay1_d   = pay1;
    exec_pos = 1'b0;
    exec_col = 1'b0;
    exec_wr  = 1'b0;
    if (timeout_hit) begin
      state_d = CMD;
      rem_d   = 2'd0;
    end else if (byte_valid) begin
      case (state)
        CMD: begin
          op_d  = byte_in;
          rem_d = cmd_len(byte_in);
          if (cmd_len(byte_in) != 2'd0) state_d = PAYLOAD;
        end
        PAYLOAD: begin
          pay0_d = pay1[3:0];
          pay1_d = byte_in;
          rem_d  = rem_cnt - 2'd1;
          if (rem_cnt == 2'd1) begin
            state_d = CMD;
            case (op)
              8'h01:   exec_pos = 1'b1;
              8'h02:   exec_col = 1'b1;
              8'h03:   exec_wr  = 1'b1;
              default: ;
            endcase
          end
        end
        default: state_d = CMD;
      endcase
    end
  end

  assign pos_word = {pay0, pay1, byte_in};
  assign commit   = bus.next_frame && dirty;

  // Commit copies the pre-update shadows; a SET landing on the same edge keeps dirty for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_x  <= '0;
      shadow_y  <= '0;
      shadow_bg <= 6'h00;
      shadow_fg <= 6'h3F;
      act_x     <= '0;
      act_y     <= '0;
      act_bg    <= 6'h00;
      act_fg    <= 6'h3F;
      dirty     <= 1'b0;
      we_q      <= 1'b0;
      cfg_q     <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      we_q  <= exec_wr;
      cfg_q <= commit;
      if (commit) begin
        act_x  <= shadow_x;
        act_y  <= shadow_y;
        act_bg <= shadow_bg;
        act_fg <= shadow_fg;
      end
      if (exec_pos) begin
        shadow_x <= X_W'(pos_word[19:10]);
        shadow_y <= Y_W'(pos_word[9:0]);
      end
      if (exec_col) begin
        shadow_bg <= pay1[5:0];
        shadow_fg <= byte_in[5:0];
      end
      if (exec_wr) begin
        addr_q  <= pay1;
        wdata_q <= byte_in;
      end
      if (exec_pos || exec_col) dirty <= 1'b1;
      else if (commit)          dirty <= 1'b0;
    end
  end

  assign bus.sprite_x     = act_x;
  assign bus.sprite_y     = act_y;
  assign bus.color_bg     = act_bg;
  assign bus.color_fg     = act_fg;
  assign bus.sprite_we    = we_q;
  assign bus.sprite_addr  = addr_q;
  assign bus.sprite_wdata = wdata_q;
  assign bus.cfg_update   = cfg_q;
  assign bus.busy         = busy;
  assign bus.state_dbg    = (state == PAYLOAD);
endmodule

// File: tb/tb_sprite_cfg_sequencer.sv
// Bench for sprite_cfg_sequencer: directed scenarios plus random command traffic,
// checked every cycle against a byte/command-level reference model.
`timescale 1ns/1ps
module tb_sprite_cfg_sequencer;
  localparam int SS = 2;
  localparam int TO = 200;
  localparam int XW = 10;
  localparam int YW = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sprite_cfg_if #(.X_W(XW), .Y_W(YW)) bus();

  sprite_cfg_sequencer #(.SYNC_STAGES(SS), .TIMEOUT(TO), .X_W(XW), .Y_W(YW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit nf_rand = 1'b0;

  int   ev_cyc[$];
  logic ev_bit[$];

  // reference model state
  int          m_bits, m_need, m_idle;
  logic [7:0]  m_byte, m_op, m_addr, m_wdata;
  logic [7:0]  m_pay[$];
  bit          m_pay_mode, m_dirty, m_we, m_cfg, m_set, m_commit, m_edge, m_busy_pre, m_bit;
  logic [XW-1:0] m_sx, m_ax;
  logic [YW-1:0] m_sy, m_ay;
  logic [5:0]  m_sbg, m_sfg, m_bg, m_fg;
  logic [23:0] m_p;

  int         we_cnt = 0;
  int         cfg_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_wdata = 8'h00;

  function automatic int len_of(input logic [7:0] opc);
    case (opc)
      8'h01:        return 3;
      8'h02, 8'h03: return 2;
      default:      return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte assembly, command decode and frame commit from the pin-level event stream.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_bits = 0; m_need = 0; m_idle = 0; m_byte = 8'h00; m_op = 8'h00;
      m_pay.delete(); m_pay_mode = 1'b0;
      m_sx = '0; m_sy = '0; m_ax = '0; m_ay = '0;
      m_sbg = 6'h00; m_sfg = 6'h3F; m_bg = 6'h00; m_fg = 6'h3F;
      m_dirty = 1'b0; m_we = 1'b0; m_cfg = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
      ev_cyc.delete(); ev_bit.delete();
    end else begin
      m_we = 1'b0; m_cfg = 1'b0; m_set = 1'b0;
      m_commit = bus.next_frame && m_dirty;
      if (m_commit) begin
        m_ax = m_sx; m_ay = m_sy; m_bg = m_sbg; m_fg = m_sfg; m_cfg = 1'b1;
      end
      m_busy_pre = (m_bits != 0) || m_pay_mode;
      m_edge = 1'b0;
      m_bit = 1'b0;
      if (ev_cyc.size() > 0 && ev_cyc[0] <= cyc) begin
        m_edge = 1'b1;
        m_bit  = ev_bit[0];
        void'(ev_cyc.pop_front());
        void'(ev_bit.pop_front());
      end
      if (m_edge) begin
        m_idle = 0;
        m_byte = {m_byte[6:0], m_bit};
        m_bits = m_bits + 1;
        if (m_bits == 8) begin
          m_bits = 0;
          if (!m_pay_mode) begin
            m_op = m_byte;
            m_need = len_of(m_byte);
            m_pay.delete();
            if (m_need > 0) m_pay_mode = 1'b1;
          end else begin
            m_pay.push_back(m_byte);
            if (m_pay.size() == m_need) begin
              m_pay_mode = 1'b0;
              case (m_op)
                8'h01: begin
                  m_p = {m_pay[0], m_pay[1], m_pay[2]};
                  m_sx = m_p[19:10]; m_sy = m_p[9:0]; m_set = 1'b1;
                end
                8'h02: begin
                  m_sbg = m_pay[0][5:0]; m_sfg = m_pay[1][5:0]; m_set = 1'b1;
                end
                8'h03: begin
                  m_we = 1'b1; m_addr = m_pay[0]; m_wdata = m_pay[1];
                end
                default: ;
              endcase
            end
          end
        end
      end else if (m_busy_pre) begin
        m_idle = m_idle + 1;
        if (m_idle == TO) begin
          m_idle = 0; m_bits = 0; m_pay_mode = 1'b0; m_pay.delete();
        end
      end else begin
        m_idle = 0;
      end
      if (m_set)         m_dirty = 1'b1;
      else if (m_commit) m_dirty = 1'b0;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("sprite_x",   32'(bus.sprite_x),   32'(m_ax));
      check("sprite_y",   32'(bus.sprite_y),   32'(m_ay));
      check("color_bg",   32'(bus.color_bg),   32'(m_bg));
      check("color_fg",   32'(bus.color_fg),   32'(m_fg));
      check("sprite_we",  32'(bus.sprite_we),  32'(m_we));
      check("cfg_update", 32'(bus.cfg_update), 32'(m_cfg));
      check("busy",       32'(bus.busy),       32'((m_bits != 0) || m_pay_mode));
      check("state_dbg",  32'(bus.state_dbg),  32'(m_pay_mode));
      if (m_we) begin
        check("sprite_addr",  32'(bus.sprite_addr),  32'(m_addr));
        check("sprite_wdata", 32'(bus.sprite_wdata), 32'(m_wdata));
      end
      if (bus.sprite_we) begin
        we_cnt++;
        last_addr  = bus.sprite_addr;
        last_wdata = bus.sprite_wdata;
      end
      if (bus.cfg_update) cfg_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (nf_rand) bus.next_frame = ($urandom_range(0, 11) == 0);
  endtask

  task automatic send_bit(input logic b, input int ph);
    bus.spi_data = b;
    bus.spi_clk  = 1'b0;
    repeat (ph) tick();
    bus.spi_clk = 1'b1;
    ev_cyc.push_back(cyc + 1 + SS);
    ev_bit.push_back(b);
    repeat (ph) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    for (int i = 7; i >= 0; i--)
      send_bit(b[i], rnd ? int'($urandom_range(SS + 1, SS + 4)) : SS + 1);
  endtask

  task automatic settle();
    repeat (SS + 4) tick();
  endtask

  task automatic pulse_nf();
    bus.next_frame = 1'b1;
    tick();
    bus.next_frame = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int c0, w0, t, n;
    logic [7:0] opc;
    bus.spi_clk = 1'b0;
    bus.spi_data = 1'b0;
    bus.next_frame = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst color_fg", 32'(bus.color_fg), 32'h3F);
    check("rst busy",     32'(bus.busy), 32'h0);
    check("rst sprite_x", 32'(bus.sprite_x), 32'h0);

    // reset in the middle of a byte
    send_bit(1'b1, SS + 1); send_bit(1'b0, SS + 1); send_bit(1'b1, SS + 1); send_bit(1'b1, SS + 1);
    bus.spi_clk = 1'b0;
    repeat (4) tick();
    check("midbyte busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("postrst busy",     32'(bus.busy), 32'h0);
    check("postrst color_fg", 32'(bus.color_fg), 32'h3F);
    send_byte(8'h00, 1'b0);
    settle();
    check("nop busy",  32'(bus.busy), 32'h0);
    check("nop state", 32'(bus.state_dbg), 32'h0);

    // timeout aborts a partial SET_POS
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    settle();
    check("partial busy", 32'(bus.busy), 32'h1);
    repeat (TO + 20) tick();
    check("timeout busy", 32'(bus.busy), 32'h0);
    send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h30, 1'b0);
    settle();
    pulse_nf();
    check("to color_bg", 32'(bus.color_bg), 32'h03);
    check("to color_fg", 32'(bus.color_fg), 32'h30);
    check("to sprite_x", 32'(bus.sprite_x), 32'h0);

    // SET_POS then commit
    c0 = cfg_cnt;
    send_byte(8'h01, 1'b0); send_byte(8'h0C, 1'b0); send_byte(8'h83, 1'b0); send_byte(8'h20, 1'b0);
    settle();
    check("pos precommit x", 32'(bus.sprite_x), 32'h0);
    check("pos precommit y", 32'(bus.sprite_y), 32'h0);
    pulse_nf();
    check("pos x", 32'(bus.sprite_x), 32'h320);
    check("pos y", 32'(bus.sprite_y), 32'h320);
    check("pos cfg pulses", 32'(cfg_cnt - c0), 32'd1);
    pulse_nf();
    check("clean nf cfg pulses", 32'(cfg_cnt - c0), 32'd1);

    // WRITE_SPRITE
    w0 = we_cnt; c0 = cfg_cnt;
    send_byte(8'h03, 1'b0); send_byte(8'h5A, 1'b0); send_byte(8'hC3, 1'b0);
    settle();
    check("wr pulses", 32'(we_cnt - w0), 32'd1);
    check("wr addr",   32'(last_addr), 32'h5A);
    check("wr data",   32'(last_wdata), 32'hC3);
    check("wr no cfg", 32'(cfg_cnt - c0), 32'd0);

    // race: SET_COLOR executes on the same edge that samples next_frame
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b0);
    settle();
    c0 = cfg_cnt;
    send_byte(8'h02, 1'b0); send_byte(8'h30, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h0C >> i), SS + 1);
    bus.spi_data = 1'b0;
    bus.spi_clk  = 1'b0;
    repeat (SS + 1) tick();
    bus.spi_clk = 1'b1;
    t = cyc + 1 + SS;
    ev_cyc.push_back(t);
    ev_bit.push_back(1'b0);
    while (cyc < t - 1) tick();
    bus.next_frame = 1'b1;
    tick();
    bus.next_frame = 1'b0;
    settle();
    check("race bg old",  32'(bus.color_bg), 32'h03);
    check("race fg old",  32'(bus.color_fg), 32'h30);
    check("race x",       32'(bus.sprite_x), 32'h1);
    check("race y",       32'(bus.sprite_y), 32'h5);
    check("race cfg",     32'(cfg_cnt - c0), 32'd1);
    pulse_nf();
    check("race bg new",  32'(bus.color_bg), 32'h30);
    check("race fg new",  32'(bus.color_fg), 32'h0C);

    // unknown opcode is ignored
    w0 = we_cnt;
    send_byte(8'hFF, 1'b0);
    settle();
    check("unk busy", 32'(bus.busy), 32'h0);
    send_byte(8'h03, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    settle();
    check("unk wr pulses", 32'(we_cnt - w0), 32'd1);
    check("unk wr addr",   32'(last_addr), 32'h01);
    check("unk wr data",   32'(last_wdata), 32'h02);

    // random command traffic with random frame pulses and occasional aborted bytes
    nf_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 6);
      if (n == 6) begin
        for (int j = 0; j < int'($urandom_range(1, 12)); j++)
          send_bit(1'($urandom_range(0, 1)), $urandom_range(SS + 1, SS + 4));
        repeat (TO + 10) tick();
      end else begin
        opc = (n >= 4) ? 8'($urandom_range(0, 255)) : 8'(n);
        send_byte(opc, 1'b1);
        for (int j = 0; j < len_of(opc); j++) send_byte(8'($urandom_range(0, 255)), 1'b1);
      end
      repeat ($urandom_range(0, 5)) tick();
    end
    nf_rand = 1'b0;
    bus.next_frame = 1'b0;
    settle();
    pulse_nf();
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_cfg_sequencer.md
# sprite_cfg_sequencer

Configuration sequencer between the two-wire SPI pins and the sprite/SVGA datapath. It deserialises SPI bytes, decodes fixed-length commands, and drives the sprite bitmap write port directly. Position and colour updates are held in shadow registers and committed atomically on the `next_frame` pulse, so the pixel pipeline never shows a torn frame. It sits between the top-level pin mapping and the sprite renderer, in the `clk` domain.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for `spi_clk` and `spi_data`; minimum 2.
- `TIMEOUT`, 1024: number of `clk` cycles without an SPI rising edge that aborts a partial byte or command.
- `X_W`, 10: sprite X coordinate width.
- `Y_W`, 10: sprite Y coordinate width.

Ports:
- `clk`, in, 1: system/pixel clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `spi_clk`, in, 1: SPI clock, asynchronous to `clk`. Mode 0; data is sampled on the rising edge.
- `spi_data`, in, 1: SPI data, MSB first.
- `next_frame`, in, 1: one-cycle pulse from the timing generator at the start of vertical blank.
- `sprite_x`, out, X_W: active sprite X position.
- `sprite_y`, out, Y_W: active sprite Y position.
- `color_bg`, out, 6: active background colour (`rrggbb`).
- `color_fg`, out, 6: active sprite colour (`rrggbb`).
- `sprite_we`, out, 1: one-cycle write strobe to the sprite bitmap RAM.
- `sprite_addr`, out, 8: sprite RAM address, valid while `sprite_we` is high.
- `sprite_wdata`, out, 8: sprite RAM data, valid while `sprite_we` is high.
- `cfg_update`, out, 1: one-cycle pulse when shadow values are committed.
- `busy`, out, 1: high while a byte or command is partially received.

## Operation

- **Input sync:** `spi_clk` and `spi_data` each pass through a `SYNC_STAGES` flop chain. A rising edge is detected when the synchronised clock is 1 and its previous value is 0. On that cycle, synchronised `spi_data` is shifted into an 8-bit register (MSB first) and the 3-bit bit counter increments.
- **Byte framing:** after the 8th edge, `byte_valid` pulses internally and the bit counter wraps to 0.
- **State machine:** two states, `CMD` and `PAYLOAD`. In `CMD`, a valid byte is decoded into an opcode and payload length `n`.
  - `n == 0`: stay in `CMD`.
  - Otherwise: load `n` into the remaining-byte counter and go to `PAYLOAD`.
  - In `PAYLOAD`, each byte is stored. When the last byte arrives, the command executes and the state returns to `CMD`.
- **Opcodes (payload length):**
  - `0x00` NOP (0).
  - `0x01` SET_POS (3): payload `p[23:0]`; `shadow_x = p[19:10]`, `shadow_y = p[9:0]`; `p[23:20]` is ignored. Sets `dirty`.
  - `0x02` SET_COLOR (2): `shadow_bg = byte0[5:0]`, `shadow_fg = byte1[5:0]`. Sets `dirty`.
  - `0x03` WRITE_SPRITE (2): byte0 is the address, byte1 is the data. Drives `sprite_we` for one cycle. Not shadowed.
  - Any other opcode: ignored, length 0, stays in `CMD`.
- **Commit:** on `next_frame` with `dirty == 1`, all shadows are copied to the active outputs, `dirty` clears, and `cfg_update` pulses. With `dirty == 0`, `next_frame` has no effect.
- **Same-cycle execute and commit:** if a SET command executes in the same cycle as `next_frame`, the commit uses the pre-update shadow values. `dirty` remains 1, so the new values commit at the following `next_frame`.
- **Timeout:** the idle counter resets on every detected edge and counts only while `busy` is high. When it reaches `TIMEOUT`:
  - the bit counter goes to 0 and the state to `CMD`;
  - the partial payload is discarded;
  - shadows, `dirty` and the active outputs are unchanged.
- **`busy`:** equals `(bit_cnt != 0) || (state == PAYLOAD)`.

## Timing

- **Reset values:**
  - `sprite_x`, `sprite_y`, shadows, and `color_bg` reset to 0.
  - `color_fg` and shadow fg reset to `6'h3F`.
  - `sprite_we`, `cfg_update`, `busy`, `dirty`, `sprite_addr`, `sprite_wdata` reset to 0.
  - State is `CMD`; all counters are 0.
- **Reset mid-command:** an asserted `reset` aborts immediately. The first edge after release is treated as bit 7 of a new opcode.
- **Input latency:** a pin edge reaches the edge detector `SYNC_STAGES`+1 `clk` cycles later.
- **Execute latency:** on the cycle after the edge carrying the last bit of a command, the command executes (`sprite_we` high, or shadow written).
- **Commit latency:** active outputs and `cfg_update` change on the cycle after `next_frame` is sampled high.
- **SPI clock limit:** the SPI clock must have each phase ≥ `SYNC_STAGES`+1 `clk` cycles. Faster input is unsupported and is not detected.
- **Back-to-back commands:** no gaps are required between bytes or commands.

## Test plan

- **Reset:** assert `reset` mid-byte, then release → all outputs at reset values, `color_fg=0x3F`, `busy=0`; the next byte `0x00` is decoded cleanly.
- **SET_POS then commit:** send `0x01 0x0C 0x83 0x20` → `sprite_x` and `sprite_y` are unchanged before `next_frame`. After the `next_frame` pulse, `sprite_x=0x320` (800) and `sprite_y=0x320`, with `cfg_update` high for exactly 1 cycle.
- **WRITE_SPRITE:** send `0x03 0x5A 0xC3` → exactly one cycle with `sprite_we=1`, `sprite_addr=0x5A`, `sprite_wdata=0xC3`, and no `cfg_update`.
- **Race:** time the last bit of `0x02 0x30 0x0C` so it executes in the same cycle as `next_frame`. Required: `color_bg` and `color_fg` keep their old values; on the next `next_frame`, `color_bg=0x30`, `color_fg=0x0C`.
- **Timeout:** send `0x01 0x00` and then stall for `TIMEOUT` cycles → `busy` falls and the shadows are unchanged. Next send `0x02 0x03 0x30` and pulse `next_frame` → `color_bg=0x03`, `color_fg=0x30`, `sprite_x` still 0.
- **Unknown opcode:** send `0xFF` followed by `0x03 0x01 0x02` → 0xFF is ignored and the sprite write goes to address 0x01 with data 0x02.
